sdram_emu: RTL and testbench

Block-RAM-backed responder for the tester's sweep interface (`start`/`rnw`/`done`/`ready`/`wdat`/`rdat`). It stands in for the external SDRAM controller so the tester, random-vector generator and pass/fail counters can be exercised on-chip, without an SDRAM module fitted. Each `start` runs one full-address sweep: a write sweep that stores `wdat`, or a read sweep that returns stored data. Per-word handshake timing matches what the tester expects from the real controller.

---
 rtl/sdram_emu_if.sv | 21 ++
 rtl/sdram_emu.sv | 127 ++++++++++++
 tb/tb_sdram_emu.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_emu_if.sv
// Sweep-interface bundle between the tester (master) and the SDRAM stand-in (slave).
interface sdram_emu_if;
    logic        start;
    logic        rnw;
    logic [1:0]  sz;
    logic [15:0] wdat;
    logic        inject_err;
    logic        done;
    logic        ready;
    logic [15:0] rdat;

    modport master (
        output start, rnw, sz, wdat, inject_err,
        input  done, ready, rdat
    );

    modport slave (
        input  start, rnw, sz, wdat, inject_err,
        output done, ready, rdat
    );
endinterface

// File: rtl/sdram_emu.sv
// Block-RAM responder that mimics the SDRAM controller's sweep handshake so the
// tester can run on-chip without external memory. RAM contents survive reset.
//
// state  | meaning
// S_INIT | power-up wait, INIT_CYCLES down-count before first done
// S_IDLE | done=1, waiting for start
// S_RUN  | one word per cycle, address 0..N-1
// S_GAP  | emulated refresh, REFRESH_GAP idle cycles
module sdram_emu #(
    parameter int AW             = 10,
    parameter int INIT_CYCLES    = 100,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_GAP    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    sdram_emu_if.slave  bus
);
    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int GW = (REFRESH_GAP > 1) ? $clog2(REFRESH_GAP) : 1;
    localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

    typedef logic [AW:0] addr_t;
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_RUN, S_GAP} state_t;

    state_t          state;
    logic [IW-1:0]   init_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [RW-1:0]   ref_cnt;
    addr_t           addr;
    addr_t           last;
    addr_t           sweep_last;
    logic [AW-1:0]   xfer_addr;
    logic            rnw_q;
    logic            done_q;
    logic            ready_q;
    logic [15:0]     rdat_q;
    logic [15:0]     mem [0:(1<<AW)-1];

    always_comb begin
        sweep_last = '0;
        case (bus.sz)
            2'd0:    sweep_last = addr_t'((1 << (AW-3)) - 1);
            2'd1:    sweep_last = addr_t'((1 << (AW-2)) - 1);
            2'd2:    sweep_last = addr_t'((1 << (AW-1)) - 1);
            default: sweep_last = addr_t'((1 << AW) - 1);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            init_cnt  <= IW'(INIT_CYCLES - 1);
            gap_cnt   <= '0;
            ref_cnt   <= '0;
            addr      <= '0;
            last      <= '0;
            xfer_addr <= '0;
            rnw_q     <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
            rdat_q    <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    ready_q <= 1'b0;
                    if (init_cnt == '0) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    ready_q <= 1'b0;
                    // done gates acceptance so start in the cycle right after a sweep is ignored
                    if (done_q && bus.start) begin
                        done_q  <= 1'b0;
                        rnw_q   <= bus.rnw;
                        last    <= sweep_last;
                        addr    <= '0;
                        ref_cnt <= RW'(REFRESH_PERIOD - 1);
                        state   <= S_RUN;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    ready_q   <= 1'b1;
                    xfer_addr <= addr[AW-1:0];
                    if (rnw_q)
                        rdat_q <= mem[addr[AW-1:0]];
                    addr <= addr + 1'b1;
                    if (ref_cnt == '0)
                        ref_cnt <= RW'(REFRESH_PERIOD - 1);
                    else
                        ref_cnt <= ref_cnt - 1'b1;
                    if (addr == last) begin
                        state <= S_IDLE;
                    end else if (ref_cnt == '0 && REFRESH_GAP > 0) begin
                        state   <= S_GAP;
                        gap_cnt <= GW'(REFRESH_GAP - 1);
                    end
                end
                S_GAP: begin
                    ready_q <= 1'b0;
                    if (gap_cnt == '0)
                        state <= S_RUN;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // Write lands at the end of the strobe cycle, while the tester still holds wdat
    always_ff @(posedge clk) begin
        if (ready_q && !rnw_q)
            mem[xfer_addr] <= bus.wdat;
    end

    assign bus.done  = done_q;
    assign bus.ready = ready_q;
    assign bus.rdat  = rdat_q ^ {15'b0, bus.inject_err & ready_q & rnw_q};

endmodule

// File: tb/tb_sdram_emu.sv
// Scoreboard bench for sdram_emu: sweep task drives and checks handshake timing,
// a monitor pops expected read data whenever ready is presented.
module tb_sdram_emu;
    localparam int INIT = 100;
    localparam int PER  = 64;
    localparam int GAP  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdram_emu_if bus();

    sdram_emu #(
        .AW(10), .INIT_CYCLES(INIT), .REFRESH_PERIOD(PER), .REFRESH_GAP(GAP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    bit          rd_mode  = 1'b0;
    logic [15:0] mon_e;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int k, input logic [15:0] px,
                                        input int split, input logic [15:0] px2);
        return (k < split) ? (16'(k) ^ px) : (16'(k) ^ px2);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rd_mode && bus.ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("rdat_unexpected_word", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rdat", int'(bus.rdat), int'(mon_e));
                end
            end
        end
    end

    // Entered at a negedge with rst_n low; releases reset and checks the INIT window.
    task automatic init_check(input string tag);
        bit done_early = 1'b0;
        bit rdy_seen   = 1'b0;
        check({tag, "_rst_done"}, int'(bus.done), 0);
        check({tag, "_rst_ready"}, int'(bus.ready), 0);
        check({tag, "_rst_rdat"}, int'(bus.rdat), 0);
        rst_n = 1'b1;
        for (int i = 1; i <= INIT; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ready !== 1'b0) rdy_seen = 1'b1;
            if (i < INIT && bus.done !== 1'b0) done_early = 1'b1;
            if (i == INIT - 1) check({tag, "_done_at_99"}, int'(bus.done), 0);
            if (i == INIT)     check({tag, "_done_at_100"}, int'(bus.done), 1);
            bus.start = (i == 50);
            bus.rnw   = 1'b1;
        end
        bus.start = 1'b0;
        check({tag, "_done_low_window"}, int'(done_early), 0);
        check({tag, "_no_ready_in_init"}, int'(rdy_seen), 0);
    endtask

    task automatic sweep(input string tag, input bit r, input logic [1:0] s,
                         input int n, input int span,
                         input logic [15:0] px, input int split, input logic [15:0] px2,
                         input int inj_lo, input int inj_hi,
                         input bit poke, input int abort_at);
        int c, words, first_c, last_c, guard, bad, expd;
        bit both, aborted, prev_ready;
        int wc[1024];
        logic [15:0] e;

        guard = 0;
        while (bus.done !== 1'b1 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_done_before_start"}, int'(bus.done), 1);

        if (r) begin
            for (int k = 0; k < n; k++) begin
                e = pat(k, px, split, px2);
                if (k >= inj_lo && k <= inj_hi) e = e ^ 16'h0001;
                exp_q.push_back(e);
            end
        end
        rd_mode        = r;
        bus.wdat       = pat(0, px, split, px2);
        bus.inject_err = r && (inj_lo <= 0) && (inj_hi >= 0);
        bus.start      = 1'b1;
        bus.rnw        = r;
        bus.sz         = s;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.rnw   = ~r;
        bus.sz    = ~s;
        check({tag, "_done_drop"}, int'(bus.done), 0);

        c = 0; words = 0; first_c = -1; last_c = -1;
        both = 1'b0; aborted = 1'b0; prev_ready = 1'b0;
        while (c < 3000) begin
            @(posedge clk);
            #1;
            if (prev_ready && !r) bus.wdat = pat(words, px, split, px2);
            @(negedge clk);
            c++;
            if (bus.ready === 1'b1 && bus.done === 1'b1) both = 1'b1;
            prev_ready = (bus.ready === 1'b1);
            if (bus.ready === 1'b1) begin
                if (first_c < 0) first_c = c;
                if (words < 1024) wc[words] = c;
                last_c = c;
                words++;
            end
            if (bus.done === 1'b1) break;
            bus.inject_err = r && (words >= inj_lo) && (words <= inj_hi);
            bus.start      = poke && (words == 5) && (bus.ready === 1'b1);
            if (abort_at > 0 && words == abort_at + 1) begin
                #2;
                rst_n = 1'b0;
                #1;
                check({tag, "_abort_ready"}, int'(bus.ready), 0);
                check({tag, "_abort_done"}, int'(bus.done), 0);
                aborted = 1'b1;
                break;
            end
        end
        bus.start      = 1'b0;
        bus.inject_err = 1'b0;
        rd_mode        = 1'b0;
        if (aborted) begin
            exp_q.delete();
            return;
        end

        check({tag, "_finished_in_budget"}, int'(bus.done === 1'b1), 1);
        check({tag, "_first_ready"}, first_c, 1);
        check({tag, "_word_count"}, words, n);
        check({tag, "_span"}, last_c - first_c + 1, span);
        check({tag, "_done_rise"}, c, last_c + 1);
        check({tag, "_done_ready_overlap"}, int'(both), 0);
        bad = 0;
        for (int k = 0; k + 1 < words && k + 1 < 1024; k++) begin
            expd = (((k + 1) % PER) == 0) ? GAP + 1 : 1;
            if (wc[k+1] - wc[k] != expd) bad++;
        end
        check({tag, "_gap_placement"}, bad, 0);
        check({tag, "_scoreboard_empty"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.rnw        = 1'b0;
        bus.sz         = 2'd0;
        bus.wdat       = '0;
        bus.inject_err = 1'b0;
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);
        init_check("init0");

        // 1024 words: 15 gaps of 4 -> 1084 cycles; 512 words: 7 gaps -> 540; 128 words: 1 gap -> 132
        sweep("wr_full",  1'b0, 2'd3, 1024, 1084, 16'hA5A5, 1 << 30, 16'hA5A5, -1, -1, 1'b1, 0);
        sweep("rd_full",  1'b1, 2'd3, 1024, 1084, 16'hA5A5, 1 << 30, 16'hA5A5, 10, 12, 1'b0, 0);
        sweep("rd_sz0",   1'b1, 2'd0,  128,  132, 16'hA5A5, 1 << 30, 16'hA5A5, -1, -1, 1'b0, 0);
        sweep("wr_abort", 1'b0, 2'd3, 1024, 1084, 16'h5A5A, 1 << 30, 16'h5A5A, -1, -1, 1'b0, 500);
        repeat (3) @(negedge clk);
        init_check("init1");
        sweep("rd_sz2",   1'b1, 2'd2,  512,  540, 16'h5A5A, 500, 16'hA5A5, -1, -1, 1'b1, 0);
        sweep("rd_sz0b",  1'b1, 2'd0,  128,  132, 16'h5A5A, 1 << 30, 16'h5A5A, -1, -1, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
